// File: rtl/idma_pow2_rsp_merger.sv
// rtl/idma_pow2_rsp_merger.sv - collects the N piece responses of a pow2-split transfer into one response
// Optional: define IDMA_RSP_MERGER_ERR_CNT_EN to add err_cnt_o (error pieces in the current transfer).
module idma_pow2_rsp_merger #(
  parameter int unsigned PieceCntWidth = 8,
  parameter int unsigned CntFifoDepth  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cnt_valid_i,
  output logic                     cnt_ready_o,
  input  logic [PieceCntWidth-1:0] cnt_i,
  input  logic                     rsp_valid_i,
  output logic                     rsp_ready_o,
  input  logic [1:0]               rsp_i,
  output logic                     merged_valid_o,
  input  logic                     merged_ready_i,
  output logic [1:0]               merged_rsp_o,
`ifdef IDMA_RSP_MERGER_ERR_CNT_EN
  output logic                     busy_o,
  output logic [PieceCntWidth-1:0] err_cnt_o
`else
  output logic                     busy_o
`endif
);

  localparam int unsigned PtrW = $clog2(CntFifoDepth);
  localparam logic [PieceCntWidth-1:0] CntOne = PieceCntWidth'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_e;

  state_e                   state_q, state_d;
  logic [PieceCntWidth-1:0] fifo_mem [CntFifoDepth];
  logic [PtrW:0]            wr_ptr_q, rd_ptr_q;
  logic                     fifo_empty, fifo_full, push, pop;
  logic [PieceCntWidth-1:0] head, remaining_q, remaining_d;
  logic                     err_seen_q, err_seen_d, all_ex_q, all_ex_d;
  logic [1:0]               merged_rsp_q, merged_rsp_d;
  logic                     rsp_hs;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                       (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign cnt_ready_o = !fifo_full;
  assign push        = cnt_valid_i && !fifo_full;
  assign head        = fifo_mem[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q[PtrW-1:0]] <= cnt_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      remaining_q  <= '0;
      err_seen_q   <= 1'b0;
      all_ex_q     <= 1'b0;
      merged_rsp_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      err_seen_q   <= err_seen_d;
      all_ex_q     <= all_ex_d;
      merged_rsp_q <= merged_rsp_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    err_seen_d   = err_seen_q;
    all_ex_d     = all_ex_q;
    merged_rsp_d = merged_rsp_q;
    pop          = 1'b0;
    rsp_hs       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      COLLECT: begin
        rsp_hs = rsp_valid_i;
        if (rsp_valid_i) begin
          remaining_d = remaining_q - CntOne;
          all_ex_d    = all_ex_q && (rsp_i == 2'b01);
          // The first error wins; otherwise EXOKAY only survives an all-EXOKAY run.
          if (!err_seen_q) begin
            if (rsp_i[1]) begin
              merged_rsp_d = rsp_i;
              err_seen_d   = 1'b1;
            end else begin
              merged_rsp_d = all_ex_d ? 2'b01 : 2'b00;
            end
          end
          if (remaining_q == CntOne) state_d = EMIT;
        end
      end
      EMIT: begin
        if (merged_ready_i) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Loading the next transfer is shared by IDLE and a completing EMIT.
    if (pop) begin
      state_d      = COLLECT;
      remaining_d  = (head == '0) ? CntOne : head;
      err_seen_d   = 1'b0;
      all_ex_d     = 1'b1;
      merged_rsp_d = 2'b00;
    end
  end

`ifdef IDMA_RSP_MERGER_ERR_CNT_EN
  logic [PieceCntWidth-1:0] err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  err_cnt_q <= '0;
    else if (pop)                 err_cnt_q <= '0;
    else if (rsp_hs && rsp_i[1])  err_cnt_q <= err_cnt_q + CntOne;
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign rsp_ready_o    = (state_q == COLLECT);
  assign merged_valid_o = (state_q == EMIT);
  assign merged_rsp_o   = merged_rsp_q;
  assign busy_o         = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_idma_pow2_rsp_merger.sv
// tb/tb_idma_pow2_rsp_merger.sv - self-checking bench for idma_pow2_rsp_merger
// Honours IDMA_RSP_MERGER_ERR_CNT_EN when the design is built with it.
module tb_idma_pow2_rsp_merger;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cnt_valid = 1'b0;
  logic         cnt_ready;
  logic [W-1:0] cnt = '0;
  logic         rsp_valid = 1'b0;
  logic         rsp_ready;
  logic [1:0]   rsp = 2'b00;
  logic         merged_valid;
  logic         merged_ready = 1'b1;
  logic [1:0]   merged_rsp;
  logic         busy;
`ifdef IDMA_RSP_MERGER_ERR_CNT_EN
  logic [W-1:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  idma_pow2_rsp_merger #(.PieceCntWidth(W), .CntFifoDepth(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cnt_valid_i    (cnt_valid),
    .cnt_ready_o    (cnt_ready),
    .cnt_i          (cnt),
    .rsp_valid_i    (rsp_valid),
    .rsp_ready_o    (rsp_ready),
    .rsp_i          (rsp),
    .merged_valid_o (merged_valid),
    .merged_ready_i (merged_ready),
    .merged_rsp_o   (merged_rsp),
`ifdef IDMA_RSP_MERGER_ERR_CNT_EN
    .busy_o         (busy),
    .err_cnt_o      (err_cnt)
`else
    .busy_o         (busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level model: counts in order, pieces of the head transfer, finished responses.
  typedef struct {
    logic [1:0] rsp;
    int         errs;
  } exp_t;

  exp_t       exp_q[$];
  int         cnt_q[$];
  logic [1:0] piece_q[$];
  int         outstanding = 0;

  function automatic exp_t reduce_pieces();
    exp_t e;
    bit   all_ex = 1'b1;
    bit   err    = 1'b0;
    e.rsp  = 2'b00;
    e.errs = 0;
    foreach (piece_q[i]) begin
      if (piece_q[i][1]) begin
        e.errs++;
        if (!err) begin
          err   = 1'b1;
          e.rsp = piece_q[i];
        end
      end
      if (piece_q[i] != 2'b01) all_ex = 1'b0;
    end
    if (!err && all_ex) e.rsp = 2'b01;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cnt_q.delete();
      piece_q.delete();
      outstanding = 0;
    end else begin
      chk("model_merged_valid", int'(merged_valid), int'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("model_merged_rsp", int'(merged_rsp), int'(exp_q[0].rsp));
`ifdef IDMA_RSP_MERGER_ERR_CNT_EN
        chk("model_err_cnt", int'(err_cnt), exp_q[0].errs);
`endif
      end
      chk("model_busy", int'(busy), int'(outstanding > 0));
      if (merged_valid && merged_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        outstanding--;
      end
      if (rsp_valid && rsp_ready) begin
        chk("model_rsp_has_cnt", int'(cnt_q.size() > 0), 1);
        if (cnt_q.size() > 0) begin
          piece_q.push_back(rsp);
          if (piece_q.size() == cnt_q[0]) begin
            exp_q.push_back(reduce_pieces());
            piece_q.delete();
            void'(cnt_q.pop_front());
          end
        end
      end
      if (cnt_valid && cnt_ready) begin
        cnt_q.push_back((cnt == '0) ? 1 : int'(cnt));
        outstanding++;
      end
    end
  end

  task automatic push_cnt(input logic [W-1:0] v);
    @(posedge clk);
    #1 cnt_valid = 1'b1;
    cnt = v;
    @(negedge clk);
    chk("push_cnt_ready", int'(cnt_ready), 1);
    @(posedge clk);
    #1 cnt_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [1:0] r);
    int n;
    n = 0;
    rsp_valid = 1'b1;
    rsp = r;
    forever begin
      @(negedge clk);
      if (rsp_ready) break;
      n++;
      if (n > 50) break;
    end
    chk("send_rsp_accepted", int'(n <= 50), 1);
    @(posedge clk);
    #1 rsp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 100) break;
    end
    chk("wait_idle_reached", int'(n <= 100), 1);
    @(posedge clk);
    #1;
  endtask

  int         t4_cnt[5] = '{2, 1, 1, 1, 1};
  int         mcyc[$];
  logic [1:0] mrsp[$];
  int         n;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_merged_valid", int'(merged_valid), 0);
    chk("reset_rsp_ready", int'(rsp_ready), 0);
    chk("reset_cnt_ready", int'(cnt_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_merged_rsp", int'(merged_rsp), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Three OKAY pieces back-to-back.
    push_cnt(8'd3);
    repeat (3) send_rsp(2'b00);
    @(negedge clk);
    chk("t1_valid_after_last", int'(merged_valid), 1);
    chk("t1_rsp_okay", int'(merged_rsp), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t1_single_pulse", int'(merged_valid), 0);
    wait_idle();

    // First error is sticky.
    push_cnt(8'd4);
    send_rsp(2'b00);
    send_rsp(2'b10);
    send_rsp(2'b11);
    send_rsp(2'b00);
    @(negedge clk);
    chk("t2_valid", int'(merged_valid), 1);
    chk("t2_rsp_slverr", int'(merged_rsp), 2);
`ifdef IDMA_RSP_MERGER_ERR_CNT_EN
    chk("t2_err_cnt", int'(err_cnt), 2);
`endif
    wait_idle();

    // Counts 1,2,1 pushed back-to-back, all EXOKAY, no IDLE bubble between transfers.
    fork
      begin
        @(posedge clk);
        #1 cnt_valid = 1'b1;
        cnt = 8'd1;
        @(posedge clk);
        #1 cnt = 8'd2;
        @(posedge clk);
        #1 cnt = 8'd1;
        @(posedge clk);
        #1 cnt_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) send_rsp(2'b01);
      end
      begin
        for (int i = 0; i < 60 && mrsp.size() < 3; i++) begin
          @(negedge clk);
          if (merged_valid) begin
            mcyc.push_back(cycle);
            mrsp.push_back(merged_rsp);
          end
        end
      end
    join
    chk("t3_count", mrsp.size(), 3);
    if (mrsp.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t3_exokay", int'(mrsp[i]), 1);
      chk("t3_gap_n2", mcyc[1] - mcyc[0], 3);
      chk("t3_gap_n1", mcyc[2] - mcyc[1], 2);
    end
    wait_idle();

    // Fill the count FIFO behind a stalled transfer, then stall in EMIT.
    merged_ready = 1'b0;
    @(posedge clk);
    #1 cnt_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cnt = W'(t4_cnt[i]);
      @(negedge clk);
      chk("t4_cnt_ready_accept", int'(cnt_ready), 1);
      @(posedge clk);
      #1;
    end
    cnt = 8'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_cnt_ready_full", int'(cnt_ready), 0);
      @(posedge clk);
      #1;
    end
    send_rsp(2'b00);
    send_rsp(2'b00);
    rsp_valid = 1'b1;
    rsp = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", int'(merged_valid), 1);
      chk("t4_hold_rsp", int'(merged_rsp), 0);
      chk("t4_hold_rsp_ready", int'(rsp_ready), 0);
      chk("t4_hold_full", int'(cnt_ready), 0);
    end
    @(posedge clk);
    #1 rsp_valid = 1'b0;
    merged_ready = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (cnt_ready) break;
      n++;
      if (n > 20) break;
    end
    chk("t4_sixth_cnt_accepted", int'(n <= 20), 1);
    @(posedge clk);
    #1 cnt_valid = 1'b0;
    repeat (5) send_rsp(2'b00);
    wait_idle();

    // A zero count means one piece.
    push_cnt(8'd0);
    send_rsp(2'b00);
    @(negedge clk);
    chk("t5_valid", int'(merged_valid), 1);
    chk("t5_rsp", int'(merged_rsp), 0);
    wait_idle();

    // Asynchronous reset in the middle of a transfer.
    push_cnt(8'd5);
    send_rsp(2'b10);
    send_rsp(2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_merged_valid", int'(merged_valid), 0);
    chk("t6_rst_rsp_ready", int'(rsp_ready), 0);
    chk("t6_rst_cnt_ready", int'(cnt_ready), 1);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_merged_rsp", int'(merged_rsp), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_busy_after_release", int'(busy), 0);
    push_cnt(8'd1);
    send_rsp(2'b01);
    @(negedge clk);
    chk("t6_valid", int'(merged_valid), 1);
    chk("t6_rsp_exokay", int'(merged_rsp), 1);
`ifdef IDMA_RSP_MERGER_ERR_CNT_EN
    chk("t6_err_cnt", int'(err_cnt), 0);
`endif
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
